// File: rtl/bnl_pkg.sv
// Package for better_neighbor_list.
// Holds the default list geometry and the FSM state type shared by the
// top level and its register-file sub-module.
package bnl_pkg;

  localparam int unsigned BNL_DEPTH = 8;   // list entries (power of 2, 2..64)
  localparam int unsigned BNL_AW    = 16;  // candidate/selected address width
  localparam int unsigned BNL_CNTW  = 16;  // width of betterNeighborCount / rng index

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQUEST,
    WAIT_RNG,
    SELECT,
    FINISH
  } state_t;

endpackage

// File: rtl/bnl_regfile.sv
// bnl_regfile: DEPTH x AW flop array holding the "better" candidate list.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   we/waddr/wdata - single synchronous write port
//   raddr/rdata    - combinational read port
//   match (BNL_DEDUP_EN only) - per-entry equality of wdata against stored
//                    entries; the caller masks it with its valid entries.
module bnl_regfile #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [AW-1:0]    wdata,
  input  logic [IW-1:0]    raddr,
  output logic [AW-1:0]    rdata
`ifdef BNL_DEDUP_EN
  ,
  output logic [DEPTH-1:0] match
`endif
);

  logic [DEPTH-1:0][AW-1:0] mem_q;
  logic [DEPTH-1:0][AW-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

`ifdef BNL_DEDUP_EN
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = (mem_q[i] == wdata);
    end
  end
`endif

endmodule

// File: rtl/better_neighbor_list.sv
// better_neighbor_list: collects addresses of "better" candidates during a
// neighbor scan, asks rngAddress for a random index, and reports the chosen
// address (or no_better when the scan found nothing).
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   start_collect           - pulse in IDLE: clear list/flags, begin scan
//   cand_valid/cand_better/cand_address/cand_last - candidate stream
//   start_rng_address       - 1-cycle request to rngAddress
//   betterNeighborCount     - registered entry count, zero-extended
//   rng_address_out/done_rng_address - index returned by rngAddress
//   selected_address/no_better/overflow/range_err/done_select - results
// Build option: define BNL_DEDUP_EN to drop better candidates whose address
// already sits in the list (such drops do not set overflow).
module better_neighbor_list
  import bnl_pkg::*;
#(
  parameter int unsigned DEPTH = BNL_DEPTH,
  parameter int unsigned AW    = BNL_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_collect,
  input  logic          cand_valid,
  input  logic          cand_better,
  input  logic [AW-1:0] cand_address,
  input  logic          cand_last,
  output logic          start_rng_address,
  output logic [15:0]   betterNeighborCount,
  input  logic [15:0]   rng_address_out,
  input  logic          done_rng_address,
  output logic [AW-1:0] selected_address,
  output logic          no_better,
  output logic          overflow,
  output logic          range_err,
  output logic          done_select
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            no_better_q, no_better_d;
  logic            range_err_q, range_err_d;
  logic [AW-1:0]   sel_q, sel_d;
  logic [15:0]     rng_idx_q, rng_idx_d;

  logic            wr_en;
  logic [IW-1:0]   rd_idx;
  logic [AW-1:0]   rd_data;
  logic [CW-1:0]   last_idx;
  logic [15:0]     count_ext;
  logic            is_dup;

  assign count_ext = {{(BNL_CNTW-CW){1'b0}}, count_q};
  assign last_idx  = count_q - CW'(1);

`ifdef BNL_DEDUP_EN
  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] valid_mask;

  always_comb begin
    valid_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_mask[i] = (i < 32'(count_q));
    end
  end

  // Stale entries beyond count may still hold old addresses; mask them out.
  assign is_dup = |(match_vec & valid_mask);
`else
  assign is_dup = 1'b0;
`endif

  bnl_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (wr_en),
    .waddr (count_q[IW-1:0]),
    .wdata (cand_address),
    .raddr (rd_idx),
    .rdata (rd_data)
`ifdef BNL_DEDUP_EN
    ,
    .match (match_vec)
`endif
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    no_better_d = no_better_q;
    range_err_d = range_err_q;
    sel_d       = sel_q;
    rng_idx_d   = rng_idx_q;
    wr_en       = 1'b0;
    rd_idx      = '0;

    unique case (state_q)
      IDLE: begin
        if (start_collect) begin
          count_d     = '0;
          overflow_d  = 1'b0;
          no_better_d = 1'b0;
          range_err_d = 1'b0;
          sel_d       = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (cand_valid && cand_better && !is_dup) begin
          if (count_q == CW'(DEPTH)) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        // Exit decision uses count_d so a better final candidate counts.
        if (cand_valid && cand_last) begin
          if (count_d != '0) begin
            state_d = REQUEST;
          end else begin
            no_better_d = 1'b1;
            state_d     = FINISH;
          end
        end
      end
      REQUEST: begin
        state_d = WAIT_RNG;
      end
      WAIT_RNG: begin
        // Capture the index here; rng_address_out is only trusted with done.
        if (done_rng_address) begin
          rng_idx_d = rng_address_out;
          state_d   = SELECT;
        end
      end
      SELECT: begin
        if (rng_idx_q >= count_ext) begin
          rd_idx      = last_idx[IW-1:0];
          range_err_d = 1'b1;
        end else begin
          rd_idx = rng_idx_q[IW-1:0];
        end
        sel_d   = rd_data;
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      no_better_q <= 1'b0;
      range_err_q <= 1'b0;
      sel_q       <= '0;
      rng_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      no_better_q <= no_better_d;
      range_err_q <= range_err_d;
      sel_q       <= sel_d;
      rng_idx_q   <= rng_idx_d;
    end
  end

  assign start_rng_address   = (state_q == REQUEST);
  assign done_select         = (state_q == FINISH);
  assign betterNeighborCount = count_ext;
  assign selected_address    = sel_q;
  assign no_better           = no_better_q;
  assign overflow            = overflow_q;
  assign range_err           = range_err_q;

endmodule

// File: tb/tb_better_neighbor_list.sv
// Self-checking bench for better_neighbor_list (DEPTH=8, AW=16).
// A list-level reference model (a queue of stored addresses) predicts the
// count, overflow, selection, range error and latency of each scan.
module tb_better_neighbor_list;

  localparam int DEPTH = 8;
`ifdef BNL_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clock, reset, start_collect, cand_valid, cand_better, cand_last;
  logic [15:0] cand_address, rng_address_out, betterNeighborCount, selected_address;
  logic        done_rng_address, start_rng_address, no_better, overflow, range_err, done_select;

  int checks = 0;
  int errors = 0;

  // Scan description
  logic [15:0] c_addr [16];
  bit          c_bet  [16];
  int          c_gap  [16];
  int          n_cand;

  // Observations from the last scan
  int          obs_pulses, obs_cnt_req, obs_done_cyc, obs_width, obs_cnt_done;
  logic [15:0] obs_sel;
  logic        obs_nb, obs_rerr, obs_ovf;

  // Model predictions
  int          exp_count, exp_lat;
  logic [15:0] exp_sel;
  logic        exp_nb, exp_rerr, exp_ovf;

  better_neighbor_list #(.DEPTH(8), .AW(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .start_collect       (start_collect),
    .cand_valid          (cand_valid),
    .cand_better         (cand_better),
    .cand_address        (cand_address),
    .cand_last           (cand_last),
    .start_rng_address   (start_rng_address),
    .betterNeighborCount (betterNeighborCount),
    .rng_address_out     (rng_address_out),
    .done_rng_address    (done_rng_address),
    .selected_address    (selected_address),
    .no_better           (no_better),
    .overflow            (overflow),
    .range_err           (range_err),
    .done_select         (done_select)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_scan(input int rng, input int lat);
    logic [15:0] q[$];
    bit dup;
    q = {};
    exp_ovf = 1'b0;
    for (int i = 0; i < n_cand; i++) begin
      if (c_bet[i]) begin
        dup = 1'b0;
        if (DEDUP) foreach (q[k]) if (q[k] == c_addr[i]) dup = 1'b1;
        if (!dup) begin
          if (q.size() == DEPTH) exp_ovf = 1'b1;
          else q.push_back(c_addr[i]);
        end
      end
    end
    exp_count = q.size();
    if (exp_count == 0) begin
      exp_nb = 1'b1; exp_sel = 16'h0; exp_rerr = 1'b0; exp_lat = 1;
    end else begin
      exp_nb   = 1'b0;
      exp_rerr = (rng >= exp_count);
      exp_sel  = exp_rerr ? q[exp_count-1] : q[rng];
      exp_lat  = (lat + 1) + 3;  // rng latency counted from the request pulse
    end
  endtask

  task automatic start_scan();
    start_collect = 1'b1;
    @(posedge clock); #1;
    start_collect = 1'b0;
  endtask

  task automatic feed_cands();
    for (int i = 0; i < n_cand; i++) begin
      for (int g = 0; g < c_gap[i]; g++) begin
        // Idle cycles carry junk that must all be ignored.
        cand_valid       = 1'b0;
        cand_better      = 1'($urandom);
        cand_address     = 16'($urandom);
        cand_last        = 1'($urandom);
        done_rng_address = 1'($urandom);
        rng_address_out  = 16'($urandom);
        start_collect    = 1'($urandom);
        @(posedge clock); #1;
      end
      cand_valid       = 1'b1;
      cand_better      = c_bet[i];
      cand_address     = c_addr[i];
      cand_last        = (i == n_cand - 1);
      done_rng_address = 1'b0;
      start_collect    = 1'($urandom);
      @(posedge clock); #1;
    end
    cand_valid = 1'b0; cand_better = 1'b0; cand_last = 1'b0;
    start_collect = 1'b0; done_rng_address = 1'b0;
  endtask

  task automatic finish_scan(input int rng_val, input int lat);
    int fire;
    bit seen;
    fire = -1; seen = 1'b0;
    obs_pulses = 0; obs_cnt_req = -1; obs_done_cyc = -1; obs_width = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (start_rng_address) begin
        obs_pulses++;
        obs_cnt_req = int'(betterNeighborCount);
        fire = cyc + 1 + lat;
      end
      if (done_select) begin
        if (!seen) begin
          seen = 1'b1; obs_done_cyc = cyc;
          obs_sel = selected_address; obs_nb = no_better; obs_rerr = range_err;
          obs_ovf = overflow; obs_cnt_done = int'(betterNeighborCount);
        end
        obs_width++;
      end else if (seen) begin
        break;
      end
      done_rng_address = (cyc == fire);
      rng_address_out  = (cyc == fire) ? 16'(rng_val) : 16'($urandom);
      start_collect    = seen ? 1'b0 : ($urandom_range(0, 3) == 0);
      @(posedge clock); #1;
    end
    done_rng_address = 1'b0; start_collect = 1'b0;
  endtask

  task automatic run_scan(input int rng_val, input int lat);
    model_scan(rng_val, lat);
    start_scan();
    feed_cands();
    finish_scan(rng_val, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_collect = 1'b0; cand_valid = 1'b0; cand_better = 1'b0; cand_last = 1'b0;
    cand_address = '0; rng_address_out = '0; done_rng_address = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (betterNeighborCount !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", betterNeighborCount); end
    checks++; if (selected_address !== 16'h0) begin errors++; $display("FAIL reset_sel got=%h exp=0", selected_address); end
    checks++; if ({start_rng_address, done_select} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {start_rng_address, done_select}); end
    checks++; if ({no_better, overflow, range_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {no_better, overflow, range_err}); end
  endtask

  task automatic test_basic();
    n_cand = 3;
    c_addr[0] = 16'h0011; c_addr[1] = 16'h0022; c_addr[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin c_bet[i] = 1'b1; c_gap[i] = 0; end
    run_scan(1, 2);
    checks++; if (obs_cnt_req !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", obs_cnt_req); end
    checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL basic_rng_pulses got=%0d exp=1", obs_pulses); end
    checks++; if (obs_sel !== 16'h0022) begin errors++; $display("FAIL basic_sel got=%h exp=0022", obs_sel); end
    checks++; if (obs_width !== 1) begin errors++; $display("FAIL basic_done_width got=%0d exp=1", obs_width); end
    checks++; if (obs_done_cyc !== exp_lat) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", obs_done_cyc, exp_lat); end
  endtask

  task automatic test_no_better();
    n_cand = 4;
    for (int i = 0; i < 4; i++) begin c_addr[i] = 16'(16'h0A00 + i); c_bet[i] = 1'b0; c_gap[i] = i % 2; end
    run_scan(3, 0);
    checks++; if (obs_nb !== 1'b1) begin errors++; $display("FAIL nobetter_flag got=%b exp=1", obs_nb); end
    checks++; if (obs_done_cyc !== 1) begin errors++; $display("FAIL nobetter_latency got=%0d exp=1", obs_done_cyc); end
    checks++; if (obs_pulses !== 0) begin errors++; $display("FAIL nobetter_rng_pulses got=%0d exp=0", obs_pulses); end
    checks++; if (obs_sel !== 16'h0) begin errors++; $display("FAIL nobetter_sel got=%h exp=0", obs_sel); end
    checks++; if (obs_width !== 1) begin errors++; $display("FAIL nobetter_done_width got=%0d exp=1", obs_width); end
  endtask

  task automatic test_overflow();
    n_cand = 10;
    for (int i = 0; i < 10; i++) begin c_addr[i] = 16'(16'h1000 + i); c_bet[i] = 1'b1; c_gap[i] = 0; end
    run_scan(7, 1);
    checks++; if (obs_cnt_done !== 8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", obs_cnt_done); end
    checks++; if (obs_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", obs_ovf); end
    checks++; if (obs_sel !== 16'h1007) begin errors++; $display("FAIL ovf_sel got=%h exp=1007", obs_sel); end
    checks++; if (obs_rerr !== 1'b0) begin errors++; $display("FAIL ovf_range_err got=%b exp=0", obs_rerr); end
  endtask

  task automatic test_range_err();
    n_cand = 3;
    c_addr[0] = 16'hBEEF; c_bet[0] = 1'b1; c_gap[0] = 1;
    c_addr[1] = 16'h1234; c_bet[1] = 1'b0; c_gap[1] = 0;
    c_addr[2] = 16'hCAFE; c_bet[2] = 1'b1; c_gap[2] = 2;
    run_scan(13, 3);
    checks++; if (obs_rerr !== 1'b1) begin errors++; $display("FAIL range_flag got=%b exp=1", obs_rerr); end
    checks++; if (obs_sel !== 16'hCAFE) begin errors++; $display("FAIL range_sel got=%h exp=cafe", obs_sel); end
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL range_ovf_cleared got=%b exp=0", obs_ovf); end
  endtask

  task automatic test_reset_midop();
    bit got_req, stray_done;
    n_cand = 2;
    c_addr[0] = 16'h0777; c_bet[0] = 1'b1; c_gap[0] = 0;
    c_addr[1] = 16'h0888; c_bet[1] = 1'b1; c_gap[1] = 0;
    start_scan();
    feed_cands();
    got_req = 1'b0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      if (start_rng_address) got_req = 1'b1;
      else begin @(posedge clock); #1; end
    end
    checks++; if (got_req !== 1'b1) begin errors++; $display("FAIL midrst_request got=%b exp=1", got_req); end
    @(posedge clock); #1;   // now waiting on rngAddress
    #2 reset = 1'b1;
    #1;
    checks++; if (betterNeighborCount !== 16'h0) begin errors++; $display("FAIL midrst_count got=%h exp=0", betterNeighborCount); end
    checks++; if ({start_rng_address, done_select, no_better, overflow, range_err} !== 5'b0)
      begin errors++; $display("FAIL midrst_outputs got=%b exp=00000", {start_rng_address, done_select, no_better, overflow, range_err}); end
    @(posedge clock); #1;
    reset = 1'b0;
    stray_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      done_rng_address = (c == 1);
      rng_address_out  = 16'h0001;
      if (done_select) stray_done = 1'b1;
      @(posedge clock); #1;
    end
    done_rng_address = 1'b0;
    checks++; if (stray_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0", stray_done); end
    run_scan(0, 0);
    checks++; if (obs_sel !== 16'h0777) begin errors++; $display("FAIL midrst_rescan_sel got=%h exp=0777", obs_sel); end
    checks++; if (obs_done_cyc !== exp_lat) begin errors++; $display("FAIL midrst_rescan_latency got=%0d exp=%0d", obs_done_cyc, exp_lat); end
  endtask

  task automatic test_dedup();
    n_cand = 3;
    c_addr[0] = 16'h0005; c_addr[1] = 16'h0005; c_addr[2] = 16'h0009;
    for (int i = 0; i < 3; i++) begin c_bet[i] = 1'b1; c_gap[i] = 0; end
    run_scan(5, 0);
    checks++; if (obs_cnt_req !== (DEDUP ? 2 : 3)) begin errors++; $display("FAIL dedup_count got=%0d exp=%0d", obs_cnt_req, DEDUP ? 2 : 3); end
    checks++; if (obs_sel !== 16'h0009) begin errors++; $display("FAIL dedup_sel got=%h exp=0009", obs_sel); end
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL dedup_ovf got=%b exp=0", obs_ovf); end
  endtask

  task automatic test_random_back_to_back();
    int rng, lat;
    for (int it = 0; it < 30; it++) begin
      n_cand = $urandom_range(1, 13);
      for (int i = 0; i < n_cand; i++) begin
        c_addr[i] = ($urandom_range(0, 1) == 0) ? 16'(16'h0100 + $urandom_range(0, 5)) : 16'($urandom);
        c_bet[i]  = ($urandom_range(0, 9) < 6);
        c_gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      rng = $urandom_range(0, 15);
      lat = $urandom_range(0, 4);
      run_scan(rng, lat);
      checks++; if (obs_done_cyc !== exp_lat) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, obs_done_cyc, exp_lat); end
      checks++; if (obs_sel !== exp_sel) begin errors++; $display("FAIL rand%0d_sel got=%h exp=%h", it, obs_sel, exp_sel); end
      checks++; if (obs_cnt_done !== exp_count) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, obs_cnt_done, exp_count); end
      checks++; if ({obs_nb, obs_rerr, obs_ovf} !== {exp_nb, exp_rerr, exp_ovf})
        begin errors++; $display("FAIL rand%0d_flags got=%b exp=%b", it, {obs_nb, obs_rerr, obs_ovf}, {exp_nb, exp_rerr, exp_ovf}); end
      checks++; if (obs_pulses !== ((exp_count > 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_rng_pulses got=%0d exp=%0d", it, obs_pulses, (exp_count > 0) ? 1 : 0); end
      checks++; if (obs_width !== 1) begin errors++; $display("FAIL rand%0d_done_width got=%0d exp=1", it, obs_width); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_better();
    test_overflow();
    test_range_err();
    test_reset_midop();
    test_dedup();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
